// File: rtl/matmul_pkg.sv
// Shared encodings, default sizes and packing helper for the matmul scheduler and its dot engine.
package matmul_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} ctrl_state_t;
    typedef enum logic [1:0] {DP_IDLE, DP_CALC, DP_OUT}       dp_state_t;

    // Flat element index of (r,c) in a row-major N x N matrix.
    function automatic int elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction
endpackage

// File: rtl/matmul_scheduler_dot_unit.sv
// Dot-product engine: latches row/column on dp_start, accumulates N cycles, then registers the result.
// Latency N+2 edges from dp_start sample to dp_done high; no backpressure, one request in flight.
module dot_unit
    import matmul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dp_start,
    input  logic [WIDTH*N-1:0] row,
    input  logic [WIDTH*N-1:0] col,
    output logic               dp_done,
    output logic [WIDTH-1:0]   result
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    dp_state_t          state, nxt;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH*N-1:0] rowq, colq;
    logic [WIDTH-1:0]   ra, ca, prod;

    always_comb begin
        ra   = rowq[k*WIDTH +: WIDTH];
        ca   = colq[k*WIDTH +: WIDTH];
        prod = ra * ca;
    end

    always_comb begin
        nxt = state;
        case (state)
            DP_IDLE: if (dp_start) nxt = DP_CALC;
            DP_CALC: if (k == KW'(N-1)) nxt = DP_OUT;
            DP_OUT:  nxt = DP_IDLE;
            default: nxt = DP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DP_IDLE;
            k       <= '0;
            acc     <= '0;
            rowq    <= '0;
            colq    <= '0;
            dp_done <= 1'b0;
            result  <= '0;
        end else begin
            state   <= nxt;
            dp_done <= 1'b0;
            case (state)
                DP_IDLE: if (dp_start) begin
                    rowq <= row;
                    colq <= col;
                    acc  <= '0;
                    k    <= '0;
                end
                DP_CALC: begin
                    acc <= acc + prod;
                    k   <= (k == KW'(N-1)) ? '0 : k + 1'b1;
                end
                DP_OUT: begin
                    result  <= acc;
                    dp_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/matmul_scheduler.sv
// C = A*B over one shared dot engine, row-major walk; N+3 cycles per element, done after edge N^2(N+3)+1.
// start ignored while busy; MATMUL_SCHED_PERF_EN adds a run-length cycle_count output.
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH*N*N-1:0] a,
    input  logic [WIDTH*N*N-1:0] b,
    output logic [WIDTH*N*N-1:0] c,
    output logic                 busy,
    output logic                 done
`ifdef MATMUL_SCHED_PERF_EN
    ,
    output logic [31:0]          cycle_count
`endif
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    ctrl_state_t          state, nxt;
    logic [IW-1:0]        i, j;
    logic [WIDTH*N*N-1:0] aq, bq;
    logic [WIDTH*N-1:0]   row_vec, col_vec;
    logic                 dp_start, dp_done, last;
    logic [WIDTH-1:0]     result;

    always_comb begin
        row_vec = '0;
        col_vec = '0;
        for (int k = 0; k < N; k++) begin
            row_vec[k*WIDTH +: WIDTH] = aq[elem_idx(int'(i), k, N)*WIDTH +: WIDTH];
            col_vec[k*WIDTH +: WIDTH] = bq[elem_idx(k, int'(j), N)*WIDTH +: WIDTH];
        end
    end

    assign last     = (i == IW'(N-1)) && (j == IW'(N-1));
    assign dp_start = (state == S_ISSUE);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_ISSUE;
            S_ISSUE: nxt = S_WAIT;
            S_WAIT:  if (dp_done) nxt = last ? S_FIN : S_ISSUE;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            i     <= '0;
            j     <= '0;
            aq    <= '0;
            bq    <= '0;
            c     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    aq   <= a;
                    bq   <= b;
                    i    <= '0;
                    j    <= '0;
                    c    <= '0;
                    busy <= 1'b1;
                end
                S_WAIT: if (dp_done) begin
                    c[elem_idx(int'(i), int'(j), N)*WIDTH +: WIDTH] <= result;
                    if (j == IW'(N-1)) begin
                        j <= '0;
                        i <= last ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MATMUL_SCHED_PERF_EN
    // Counts every edge spent outside IDLE, so a full run ends on N^2(N+3)+1.
    always_ff @(posedge clk) begin
        if (rst)
            cycle_count <= '0;
        else if (state == S_IDLE && start)
            cycle_count <= '0;
        else if (state != S_IDLE)
            cycle_count <= cycle_count + 32'd1;
    end
`endif

    dot_unit #(.WIDTH(WIDTH), .N(N)) u_dot (
        .clk      (clk),
        .rst      (rst),
        .dp_start (dp_start),
        .row      (row_vec),
        .col      (col_vec),
        .dp_done  (dp_done),
        .result   (result)
    );
endmodule
